waypoint_sequencer: RTL and testbench
=====================================

# waypoint_sequencer

Upstream mission stage for the robot controller. Holds a small table of signed (x, y) waypoints and drives them to the controller one leg at a time: `target_position_x/y`, `initial_position_x/y`, the enable and a per-leg reset. It watches `target_reached`, dwells for a programmable time, then advances. It supports single-pass or looping missions, abort, and a per-leg timeout fault.

## Interface
**Parameters**
- `DEPTH`, 8: number of waypoint slots.
- `AW`, 3: address width, equal to log2(`DEPTH`).

**Ports**
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high.
- `wp_wr_en`, in, 1: write waypoint slot `wp_wr_addr`. Ignored while `busy`=1.
- `wp_wr_addr`, in, AW: slot index.
- `wp_wr_x`, in, 32 signed: waypoint x, in cm.
- `wp_wr_y`, in, 32 signed: waypoint y, in cm.
- `wp_count`, in, AW+1: number of valid waypoints. Sampled at `start`; values above `DEPTH` are clamped to `DEPTH`.
- `start_x`, in, 32 signed: initial position for the first leg.
- `start_y`, in, 32 signed: initial position for the first leg.
- `start`, in, 1: 1-cycle pulse. Begins the mission. Ignored while `busy`=1.
- `abort`, in, 1: level. Returns the block to IDLE from any state.
- `loop_en`, in, 1: 1 = wrap to waypoint 0 after the last waypoint.
- `ms_tick`, in, 1: 1-cycle pulse once per millisecond.
- `dwell_ms`, in, 16: dwell time after each arrival.
- `timeout_ms`, in, 32: per-leg time limit. 0 disables the timeout.
- `target_reached`, in, 1: arrival flag from the controller.
- `current_x_i`, in, 32 signed: controller position, captured on arrival.
- `current_y_i`, in, 32 signed: controller position, captured on arrival.
- `target_position_x`, out, 32 signed.
- `target_position_y`, out, 32 signed.
- `initial_position_x`, out, 32 signed.
- `initial_position_y`, out, 32 signed.
- `robot_controller_en`, out, 1.
- `leg_reset`, out, 1: 1-cycle pulse that restarts the controller and odometer for a new leg.
- `busy`, out, 1.
- `done`, out, 1: sticky; cleared by `start`.
- `error_timeout`, out, 1: sticky; cleared by `start`.
- `wp_index`, out, AW: current slot.
- `legs_completed`, out, 8: saturates at 255; cleared by `start`.

## Operation
**Reset values**
- All outputs 0.
- State IDLE.
- Waypoint table cleared to 0.

**States**
- **IDLE**
  - `busy`=0, `robot_controller_en`=0.
  - `start` with clamped count 0: set `done`=1 and stay in IDLE.
  - `start` with clamped count > 0: latch count, set `wp_index`=0, load initial = (`start_x`, `start_y`), clear `done`/`error_timeout`/`legs_completed`, go to LOAD.
- **LOAD**
  - Register target = table[`wp_index`].
  - Go to RESET_LEG.
- **RESET_LEG**
  - `leg_reset`=1 and `robot_controller_en`=0 for exactly one cycle.
  - Clear the timeout and dwell counters.
  - Go to RUN.
- **RUN**
  - `robot_controller_en`=1.
  - `target_reached` is ignored during the first 2 cycles of RUN (blanking for the downstream synchroniser).
  - On `target_reached`=1:
    - Capture (`current_x_i`, `current_y_i`) as the next initial position.
    - Increment `legs_completed` (saturating).
    - Go to DWELL.
  - Each `ms_tick` increments the leg timer. When the timer equals `timeout_ms` (with `timeout_ms` ≠ 0), go to FAULT. If arrival and timeout occur in the same cycle, arrival wins.
- **DWELL**
  - `robot_controller_en` stays 1, because the controller holds position in DONE.
  - Count `ms_tick` until the count equals `dwell_ms`, then go to NEXT.
  - `dwell_ms`=0 goes to NEXT on the next cycle.
- **NEXT**
  - If `wp_index` = count−1:
    - `loop_en`=1: set `wp_index`=0 and go to LOAD.
    - `loop_en`=0: set `done`=1 and go to IDLE.
  - Otherwise increment `wp_index` and go to LOAD.
- **FAULT**
  - `robot_controller_en`=0, `error_timeout`=1, `busy`=0.
  - Go to IDLE on the next cycle.

**Other rules**
- `abort` is checked before all other transitions. It forces IDLE with `robot_controller_en`=0 and leaves `done` and `error_timeout` unchanged.
- `busy`=1 in every state except IDLE and FAULT.
- A table write addressed beyond `DEPTH`−1 is ignored.
- The table is read by synchronous register only; there is no combinational path from inputs to outputs.

## Timing
- `start` sampled at edge N:
  - Edge N+1 enters LOAD.
  - Target outputs are valid from edge N+2.
  - `leg_reset` is high for the cycle N+2 to N+3.
  - `robot_controller_en` is high from edge N+3.
  - The earliest accepted `target_reached` is sampled at edge N+5.
- Arrival at edge M, `dwell_ms`=0:
  - DWELL at M+1, NEXT at M+2, LOAD at M+3.
  - The next `leg_reset` is at M+4.
- Arrival to next leg is therefore 4 + dwell cycles.
- Timeout granularity is `ms_tick`. FAULT is entered on the edge after the terminal tick.
- `abort` takes effect at the next edge. It may be asserted mid-LOAD or mid-RESET_LEG, and no `leg_reset` pulse follows it.

## Test plan
- **Three-waypoint mission:**
  - Stimulus: table {(100,0),(100,50),(0,50)}, `wp_count`=3, `start_x`/`start_y`=(0,0), `dwell_ms`=2, `loop_en`=0. Model `target_reached` 20 cycles after each `leg_reset`.
  - Required: 3 `leg_reset` pulses; targets in order; initial positions equal the captured `current` values; `legs_completed`=3; `done`=1; `busy`=0.
- **Loop wrap:**
  - Stimulus: `wp_count`=2, `loop_en`=1.
  - Required: `wp_index` sequence 0,1,0,1.
  - Then `abort`: `robot_controller_en`=0 at the next edge and `done`=0.
- **Timeout:**
  - Stimulus: `timeout_ms`=5; `target_reached` never asserted.
  - Required: FAULT after the 5th `ms_tick` in RUN; `error_timeout`=1; `robot_controller_en`=0.
- **Blanking:**
  - Stimulus: `target_reached` held 1 from before `start`.
  - Required: not accepted until the 3rd cycle of RUN.
  - Also: `wp_count`=0 sets `done` with no `leg_reset`.
- **Busy guards:**
  - Stimulus: `start` and `wp_wr_en` pulses while `busy`.
  - Required: both ignored; the table is unchanged.
  - Also: `wp_count`=12 is clamped to 8.
- **Reset mid-RUN:**
  - Required: all outputs 0 immediately (asynchronously), the table is cleared, and state is IDLE.

Source files
------------

// File: rtl/waypoint_sequencer_if.sv
// Controller-facing leg bus: target/initial position, enable and per-leg reset go out;
// arrival flag and live position come back. No backpressure; all signals are levels or 1-cycle pulses.
interface waypoint_sequencer_if;
  logic signed [31:0] target_position_x;
  logic signed [31:0] target_position_y;
  logic signed [31:0] initial_position_x;
  logic signed [31:0] initial_position_y;
  logic               robot_controller_en;
  logic               leg_reset;
  logic               target_reached;
  logic signed [31:0] current_x_i;
  logic signed [31:0] current_y_i;

  modport master (
    output target_position_x, target_position_y,
    output initial_position_x, initial_position_y,
    output robot_controller_en, leg_reset,
    input  target_reached, current_x_i, current_y_i
  );

  modport slave (
    input  target_position_x, target_position_y,
    input  initial_position_x, initial_position_y,
    input  robot_controller_en, leg_reset,
    output target_reached, current_x_i, current_y_i
  );
endinterface

// File: rtl/waypoint_sequencer.sv
// Waypoint mission sequencer: start -> leg_reset after 2 cycles, arrival -> next leg_reset after 4 + dwell cycles.
// No backpressure: writes and start are dropped while busy, abort wins over every other transition.
module waypoint_sequencer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wp_wr_en,
  input  logic [AW-1:0]        wp_wr_addr,
  input  logic signed [31:0]   wp_wr_x,
  input  logic signed [31:0]   wp_wr_y,
  input  logic [AW:0]          wp_count,
  input  logic signed [31:0]   start_x,
  input  logic signed [31:0]   start_y,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 loop_en,
  input  logic                 ms_tick,
  input  logic [15:0]          dwell_ms,
  input  logic [31:0]          timeout_ms,
  waypoint_sequencer_if.master ctl,
  output logic                 busy,
  output logic                 done,
  output logic                 error_timeout,
  output logic [AW-1:0]        wp_index,
  output logic [7:0]           legs_completed
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RESET_LEG, S_RUN, S_DWELL, S_NEXT, S_FAULT
  } state_e;

  state_e state_q, state_d;

  logic signed [31:0] tbl_x_q [DEPTH];
  logic signed [31:0] tbl_x_d [DEPTH];
  logic signed [31:0] tbl_y_q [DEPTH];
  logic signed [31:0] tbl_y_d [DEPTH];
  logic signed [31:0] tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
  logic signed [31:0] init_x_q, init_x_d, init_y_q, init_y_d;
  logic [AW:0]        cnt_q, cnt_d;
  logic [AW-1:0]      wp_index_q, wp_index_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [7:0]         legs_q, legs_d;
  logic [31:0]        leg_timer_q, leg_timer_d;
  logic [15:0]        dwell_cnt_q, dwell_cnt_d;
  logic [1:0]         run_cyc_q, run_cyc_d;

  logic [AW:0]        cnt_clamped;
  logic               last_wp;
  logic [31:0]        leg_timer_inc;
  logic               arrive;
  logic               timed_out;
  logic               wr_ok;

  assign cnt_clamped   = (wp_count > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : wp_count;
  assign last_wp       = (({1'b0, wp_index_q} + (AW+1)'(1)) == cnt_q);
  assign leg_timer_inc = leg_timer_q + {31'd0, ms_tick};
  // The first two RUN cycles ignore target_reached so the controller-side synchroniser can settle.
  assign arrive        = (state_q == S_RUN) && (run_cyc_q == 2'd2) && ctl.target_reached;
  assign timed_out     = (state_q == S_RUN) && (timeout_ms != 32'd0) && (leg_timer_inc == timeout_ms);
  assign wr_ok         = wp_wr_en && !busy && ({1'b0, wp_wr_addr} < (AW+1)'(DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:      if (start && (cnt_clamped != '0)) state_d = S_LOAD;
        S_LOAD:      state_d = S_RESET_LEG;
        S_RESET_LEG: state_d = S_RUN;
        S_RUN: begin
          if (arrive)         state_d = S_DWELL;
          else if (timed_out) state_d = S_FAULT;
        end
        S_DWELL:     if (dwell_cnt_q == dwell_ms) state_d = S_NEXT;
        S_NEXT:      state_d = (last_wp && !loop_en) ? S_IDLE : S_LOAD;
        S_FAULT:     state_d = S_IDLE;
        default:     state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy                    = 1'b0;
    ctl.robot_controller_en = 1'b0;
    ctl.leg_reset           = 1'b0;
    case (state_q)
      S_LOAD, S_NEXT: busy = 1'b1;
      S_RESET_LEG: begin
        busy          = 1'b1;
        ctl.leg_reset = 1'b1;
      end
      S_RUN, S_DWELL: begin
        busy                    = 1'b1;
        ctl.robot_controller_en = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    tbl_x_d     = tbl_x_q;
    tbl_y_d     = tbl_y_q;
    tgt_x_d     = tgt_x_q;
    tgt_y_d     = tgt_y_q;
    init_x_d    = init_x_q;
    init_y_d    = init_y_q;
    cnt_d       = cnt_q;
    wp_index_d  = wp_index_q;
    done_d      = done_q;
    err_d       = err_q;
    legs_d      = legs_q;
    leg_timer_d = leg_timer_q;
    dwell_cnt_d = dwell_cnt_q;
    run_cyc_d   = run_cyc_q;

    if (wr_ok) begin
      tbl_x_d[wp_wr_addr] = wp_wr_x;
      tbl_y_d[wp_wr_addr] = wp_wr_y;
    end

    if (!abort) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (cnt_clamped == '0) begin
              done_d = 1'b1;
            end else begin
              cnt_d      = cnt_clamped;
              wp_index_d = '0;
              init_x_d   = start_x;
              init_y_d   = start_y;
              done_d     = 1'b0;
              err_d      = 1'b0;
              legs_d     = 8'd0;
            end
          end
        end
        S_LOAD: begin
          tgt_x_d = tbl_x_q[wp_index_q];
          tgt_y_d = tbl_y_q[wp_index_q];
        end
        S_RESET_LEG: begin
          leg_timer_d = 32'd0;
          dwell_cnt_d = 16'd0;
          run_cyc_d   = 2'd0;
        end
        S_RUN: begin
          leg_timer_d = leg_timer_inc;
          if (run_cyc_q != 2'd2) run_cyc_d = run_cyc_q + 2'd1;
          if (arrive) begin
            init_x_d = ctl.current_x_i;
            init_y_d = ctl.current_y_i;
            if (legs_q != 8'hFF) legs_d = legs_q + 8'd1;
          end else if (timed_out) begin
            err_d = 1'b1;
          end
        end
        S_DWELL: begin
          if (ms_tick && (dwell_cnt_q != dwell_ms)) dwell_cnt_d = dwell_cnt_q + 16'd1;
        end
        S_NEXT: begin
          if (last_wp) begin
            if (loop_en) wp_index_d = '0;
            else         done_d     = 1'b1;
          end else begin
            wp_index_d = wp_index_q + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_x_q[i] <= '0;
        tbl_y_q[i] <= '0;
      end
      tgt_x_q     <= '0;
      tgt_y_q     <= '0;
      init_x_q    <= '0;
      init_y_q    <= '0;
      cnt_q       <= '0;
      wp_index_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      legs_q      <= 8'd0;
      leg_timer_q <= 32'd0;
      dwell_cnt_q <= 16'd0;
      run_cyc_q   <= 2'd0;
    end else begin
      tbl_x_q     <= tbl_x_d;
      tbl_y_q     <= tbl_y_d;
      tgt_x_q     <= tgt_x_d;
      tgt_y_q     <= tgt_y_d;
      init_x_q    <= init_x_d;
      init_y_q    <= init_y_d;
      cnt_q       <= cnt_d;
      wp_index_q  <= wp_index_d;
      done_q      <= done_d;
      err_q       <= err_d;
      legs_q      <= legs_d;
      leg_timer_q <= leg_timer_d;
      dwell_cnt_q <= dwell_cnt_d;
      run_cyc_q   <= run_cyc_d;
    end
  end

  assign ctl.target_position_x  = tgt_x_q;
  assign ctl.target_position_y  = tgt_y_q;
  assign ctl.initial_position_x = init_x_q;
  assign ctl.initial_position_y = init_y_q;
  assign done                   = done_q;
  assign error_timeout          = err_q;
  assign wp_index               = wp_index_q;
  assign legs_completed         = legs_q;

endmodule

// File: tb/tb_waypoint_sequencer.sv
// Bench for waypoint_sequencer: a reactive controller model answers each leg, a scoreboard checks every leg_reset.
module tb_waypoint_sequencer;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               wp_wr_en = 1'b0;
  logic [AW-1:0]      wp_wr_addr = '0;
  logic signed [31:0] wp_wr_x = '0, wp_wr_y = '0;
  logic [AW:0]        wp_count = '0;
  logic signed [31:0] start_x = '0, start_y = '0;
  logic               start = 1'b0, abort = 1'b0, loop_en = 1'b0;
  logic               ms_tick;
  logic [15:0]        dwell_ms = '0;
  logic [31:0]        timeout_ms = '0;
  logic               busy, done, error_timeout;
  logic [AW-1:0]      wp_index;
  logic [7:0]         legs_completed;

  waypoint_sequencer_if ifc();

  waypoint_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .wp_wr_en(wp_wr_en), .wp_wr_addr(wp_wr_addr), .wp_wr_x(wp_wr_x), .wp_wr_y(wp_wr_y),
    .wp_count(wp_count), .start_x(start_x), .start_y(start_y),
    .start(start), .abort(abort), .loop_en(loop_en), .ms_tick(ms_tick),
    .dwell_ms(dwell_ms), .timeout_ms(timeout_ms),
    .ctl(ifc),
    .busy(busy), .done(done), .error_timeout(error_timeout),
    .wp_index(wp_index), .legs_completed(legs_completed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]      idx;
    logic signed [31:0] tx, ty, ix, iy;
  } leg_t;

  leg_t               exp_q[$];
  int                 n_chk = 0, n_fail = 0;
  logic signed [31:0] tbl_m_x [DEPTH];
  logic signed [31:0] tbl_m_y [DEPTH];
  logic signed [31:0] cur_x_arr [512];
  logic signed [31:0] cur_y_arr [512];
  int                 g_model = 0, leg_no = 0;
  int                 resp_mode = 0, resp_delay = 20;
  logic               resp_tr = 1'b0, force_tr = 1'b0;
  logic               auto_tick = 1'b0, rnd_tick = 1'b0, man_tick = 1'b0;

  assign ifc.target_reached = resp_tr | force_tr;
  assign ms_tick = auto_tick ? rnd_tick : man_tick;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, expv);
    end
  endtask

  // Expected legs of a mission: leg k targets slot k mod count; each later leg starts where the previous arrived.
  task automatic expect_mission(input int cnt, input int sx, input int sy, input int nlegs);
    logic signed [31:0] ix, iy;
    ix = sx;
    iy = sy;
    for (int k = 0; k < nlegs; k++) begin
      leg_t e;
      int   idx;
      idx   = k % cnt;
      e.idx = idx[AW-1:0];
      e.tx  = tbl_m_x[idx];
      e.ty  = tbl_m_y[idx];
      e.ix  = ix;
      e.iy  = iy;
      exp_q.push_back(e);
      ix = cur_x_arr[g_model];
      iy = cur_y_arr[g_model];
      g_model++;
    end
  endtask

  task automatic write_wp(input int a, input int x, input int y, input bit accept);
    wp_wr_addr = a[AW-1:0];
    wp_wr_x    = x;
    wp_wr_y    = y;
    wp_wr_en   = 1'b1;
    @(negedge clk);
    wp_wr_en   = 1'b0;
    if (accept) begin
      tbl_m_x[a] = x;
      tbl_m_y[a] = y;
    end
  endtask

  task automatic start_mission(input int cnt, input int sx, input int sy);
    wp_count = cnt[AW:0];
    start_x  = sx;
    start_y  = sy;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int i = 0;
    while (!(done === 1'b1 && busy === 1'b0) && i < bound) begin
      @(negedge clk);
      i++;
    end
    chk({name, "_finished_in_time"}, 64'(i < bound), 64'd1);
  endtask

  task automatic wait_en(input string name);
    int i = 0;
    while (ifc.robot_controller_en !== 1'b1 && i < 50) begin
      @(negedge clk);
      i++;
    end
    chk({name, "_en_seen"}, 64'(i < 50), 64'd1);
  endtask

  // Scoreboard monitor: every leg_reset pulse must match the next expected leg.
  initial begin
    forever begin
      leg_t e;
      @(negedge clk);
      if (ifc.leg_reset === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_leg_reset: got a pulse with wp_index %0d, required none", wp_index);
        end else begin
          e = exp_q.pop_front();
          chk("leg_wp_index", 64'(wp_index), 64'(e.idx));
          chk("leg_target_x", 64'(ifc.target_position_x), 64'(e.tx));
          chk("leg_target_y", 64'(ifc.target_position_y), 64'(e.ty));
          chk("leg_initial_x", 64'(ifc.initial_position_x), 64'(e.ix));
          chk("leg_initial_y", 64'(ifc.initial_position_y), 64'(e.iy));
          chk("leg_en_low", 64'(ifc.robot_controller_en), 64'd0);
        end
      end
    end
  end

  // Controller model: presents a fresh position per leg and reports arrival resp_delay cycles after leg_reset.
  initial begin
    int cnt   = 0;
    bit armed = 1'b0;
    ifc.current_x_i = '0;
    ifc.current_y_i = '0;
    forever begin
      @(negedge clk);
      resp_tr = 1'b0;
      if (ifc.leg_reset === 1'b1) begin
        if (leg_no < 512) begin
          ifc.current_x_i = cur_x_arr[leg_no];
          ifc.current_y_i = cur_y_arr[leg_no];
        end
        leg_no++;
        cnt   = 0;
        armed = (resp_mode == 0);
      end else if (armed) begin
        cnt++;
        if (cnt >= resp_delay) begin
          resp_tr = 1'b1;
          armed   = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1 rnd_tick = ($urandom_range(0, 3) == 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen, i, cnt, clamped, sx, sy;
    for (int k = 0; k < 512; k++) begin
      cur_x_arr[k] = int'($urandom_range(0, 4000)) - 2000;
      cur_y_arr[k] = int'($urandom_range(0, 4000)) - 2000;
    end
    for (int k = 0; k < DEPTH; k++) begin
      tbl_m_x[k] = '0;
      tbl_m_y[k] = '0;
    end

    repeat (3) @(negedge clk);
    chk("rst_target_x", 64'(ifc.target_position_x), 64'd0);
    chk("rst_target_y", 64'(ifc.target_position_y), 64'd0);
    chk("rst_initial_x", 64'(ifc.initial_position_x), 64'd0);
    chk("rst_initial_y", 64'(ifc.initial_position_y), 64'd0);
    chk("rst_en", 64'(ifc.robot_controller_en), 64'd0);
    chk("rst_leg_reset", 64'(ifc.leg_reset), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error_timeout), 64'd0);
    chk("rst_wp_index", 64'(wp_index), 64'd0);
    chk("rst_legs", 64'(legs_completed), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Three-waypoint mission with start/write pulses while busy.
    write_wp(0, 100, 0, 1);
    write_wp(1, 100, 50, 1);
    write_wp(2, 0, 50, 1);
    dwell_ms = 16'd2; loop_en = 1'b0; timeout_ms = 32'd0;
    auto_tick = 1'b1; resp_mode = 0; resp_delay = 20;
    expect_mission(3, 0, 0, 3);
    start_mission(3, 0, 0);
    chk("a_busy_in_load", 64'(busy), 64'd1);
    chk("a_no_leg_reset_in_load", 64'(ifc.leg_reset), 64'd0);
    @(negedge clk);
    chk("a_leg_reset_cycle", 64'(ifc.leg_reset), 64'd1);
    @(negedge clk);
    chk("a_en_after_reset_leg", 64'(ifc.robot_controller_en), 64'd1);
    chk("a_leg_reset_one_cycle", 64'(ifc.leg_reset), 64'd0);
    write_wp(1, -7, -7, 0);
    start_mission(1, 555, 555);
    wait_idle("mission_a", 3000);
    chk("a_legs_completed", 64'(legs_completed), 64'd3);
    chk("a_done", 64'(done), 64'd1);
    chk("a_busy", 64'(busy), 64'd0);
    chk("a_en", 64'(ifc.robot_controller_en), 64'd0);
    chk("a_all_legs_seen", 64'(exp_q.size()), 64'd0);

    // Randomised single-pass missions; one uses wp_count=12 which must clamp to 8.
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 4; k++)
        write_wp(int'($urandom_range(0, DEPTH-1)), int'($urandom_range(0, 20000)) - 10000,
                 int'($urandom_range(0, 20000)) - 10000, 1);
      cnt        = (r == 2) ? 12 : int'($urandom_range(1, DEPTH));
      clamped    = (cnt > DEPTH) ? DEPTH : cnt;
      dwell_ms   = 16'($urandom_range(0, 3));
      resp_delay = (r == 0) ? 3 : int'($urandom_range(3, 25));
      sx         = int'($urandom_range(0, 2000)) - 1000;
      sy         = int'($urandom_range(0, 2000)) - 1000;
      expect_mission(clamped, sx, sy, clamped);
      start_mission(cnt, sx, sy);
      wait_idle("random_mission", 3000);
      chk("rand_legs_completed", 64'(legs_completed), 64'(clamped));
      chk("rand_done", 64'(done), 64'd1);
      chk("rand_all_legs_seen", 64'(exp_q.size()), 64'd0);
    end

    // Loop wrap over two slots, then abort during RUN.
    loop_en = 1'b1; dwell_ms = 16'd1; resp_delay = 10;
    expect_mission(2, 11, -22, 5);
    start_mission(2, 11, -22);
    seen = 0; i = 0;
    while (seen < 5 && i < 3000) begin
      @(negedge clk);
      i++;
      if (ifc.leg_reset === 1'b1) seen++;
    end
    chk("loop_five_legs", 64'(seen), 64'd5);
    @(negedge clk);
    chk("loop_en_before_abort", 64'(ifc.robot_controller_en), 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_en", 64'(ifc.robot_controller_en), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    loop_en = 1'b0;
    repeat (40) @(negedge clk);
    chk("loop_all_legs_seen", 64'(exp_q.size()), 64'd0);

    // Abort during LOAD: no leg_reset may follow.
    start_mission(1, 1, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_load_busy", 64'(busy), 64'd0);
    chk("abort_load_leg_reset", 64'(ifc.leg_reset), 64'd0);
    repeat (6) @(negedge clk);
    chk("abort_load_idle", 64'(busy), 64'd0);

    // Zero-length mission sets done without a leg; abort in IDLE leaves done alone.
    start_mission(0, 3, 3);
    chk("zero_count_done", 64'(done), 64'd1);
    chk("zero_count_busy", 64'(busy), 64'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_keeps_done", 64'(done), 64'd1);
    repeat (5) @(negedge clk);

    // Timeout after the 5th tick in RUN.
    resp_mode = 1; auto_tick = 1'b0; man_tick = 1'b0; timeout_ms = 32'd5;
    expect_mission(1, 7, 8, 1);
    start_mission(1, 7, 8);
    wait_en("timeout");
    for (int t = 1; t <= 5; t++) begin
      man_tick = 1'b1;
      @(negedge clk);
      man_tick = 1'b0;
      if (t < 5) begin
        chk("timeout_not_yet", 64'(error_timeout), 64'd0);
        chk("timeout_still_busy", 64'(busy), 64'd1);
        @(negedge clk);
      end
    end
    chk("timeout_error", 64'(error_timeout), 64'd1);
    chk("timeout_en", 64'(ifc.robot_controller_en), 64'd0);
    chk("timeout_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("timeout_error_sticky", 64'(error_timeout), 64'd1);
    chk("timeout_no_done", 64'(done), 64'd0);
    chk("timeout_no_arrival", 64'(legs_completed), 64'd0);
    timeout_ms = 32'd0;

    // Blanking: target_reached high throughout, accepted only in the 3rd RUN cycle.
    force_tr = 1'b1; dwell_ms = 16'd0; auto_tick = 1'b1;
    expect_mission(2, -5, 9, 2);
    start_mission(2, -5, 9);
    i = 0;
    while (ifc.leg_reset !== 1'b1 && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk("blank_leg_reset_seen", 64'(i < 20), 64'd1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("blank_legs_count", 64'(legs_completed), (k < 4) ? 64'd0 : 64'd1);
    end
    i = 4;
    while (ifc.leg_reset !== 1'b1 && i < 30) begin
      @(negedge clk);
      i++;
    end
    chk("arrival_to_next_leg_reset", 64'(i), 64'd7);
    wait_idle("blanking", 200);
    chk("blank_legs_final", 64'(legs_completed), 64'd2);
    force_tr = 1'b0;

    // Asynchronous reset in RUN clears outputs and the table.
    resp_mode = 1;
    write_wp(0, 1234, -99, 1);
    expect_mission(1, 5, 6, 1);
    start_mission(1, 5, 6);
    wait_en("reset_run");
    #2 reset = 1'b1;
    #1;
    chk("arst_target_x", 64'(ifc.target_position_x), 64'd0);
    chk("arst_initial_y", 64'(ifc.initial_position_y), 64'd0);
    chk("arst_en", 64'(ifc.robot_controller_en), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_wp_index", 64'(wp_index), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      tbl_m_x[k] = '0;
      tbl_m_y[k] = '0;
    end
    resp_mode = 0; resp_delay = 5;
    expect_mission(2, 1, 2, 2);
    start_mission(2, 1, 2);
    wait_idle("after_reset", 500);
    chk("after_reset_legs", 64'(legs_completed), 64'd2);

    repeat (5) @(negedge clk);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
